// File: rtl/spi_slave_burst_bridge.sv
// SPI slave to single-port memory bridge: one frame carries an op bit, a start address and a
// stream of auto-incrementing data words; reads prefetch one word ahead so MISO never gaps.
module spi_slave_burst_bridge #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int TURN_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              busy,
   output logic              rd_err
);

   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      RTURN = 3'd3,
      RDATA = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                op_r;
   logic [ADDR_W-2:0]   addr_sh_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-2:0]   rx_sh_r;
   logic [DATA_W-1:0]   hold_r;
   logic                wpend_r;
   logic                rd_pend_r;
   logic                stale_r;
   logic [DATA_W-1:0]   buf_r;
   logic                buf_v_r;
   logic [DATA_W-1:0]   tx_sh_r;

   logic                ss_act_s;
   logic [ADDR_W-1:0]   addr_full_s;
   logic [DATA_W-1:0]   word_full_s;
   logic                addr_done_s;
   logic                word_done_s;
   logic                rsp_s;
   logic                fresh_s;
   logic                load_s;
   logic                avail_s;
   logic                late_s;
   logic [DATA_W-1:0]   load_word_s;
   logic                rd_start_s;
   logic                rd_issue_s;
   logic                wr_issue_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; SS_n high always returns to IDLE
   always_comb begin
      state_s = state_r;
      if (SS_n) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_s = ADDR;
            ADDR:    state_s = (cnt_r == ADDR_LAST) ? (op_r ? RTURN : WDATA) : ADDR;
            WDATA:   state_s = WDATA;
            RTURN:   state_s = (cnt_r == TURN_LAST) ? RDATA : RTURN;
            RDATA:   state_s = RDATA;
            default: state_s = IDLE;
         endcase
      end
   end

   // Per-cycle control decodes
   always_comb begin
      ss_act_s    = ~SS_n;
      addr_full_s = {addr_sh_r, MOSI};
      word_full_s = {rx_sh_r, MOSI};
      addr_done_s = ss_act_s && (state_r == ADDR) && (cnt_r == ADDR_LAST);
      word_done_s = ss_act_s && (state_r == WDATA) && (cnt_r == DATA_LAST);
      rsp_s       = mem_rvalid && rd_pend_r && ((state_r == RTURN) || (state_r == RDATA));
      fresh_s     = rsp_s && !stale_r;
      load_s      = ss_act_s && (((state_r == RTURN) && (cnt_r == TURN_LAST)) ||
                                 ((state_r == RDATA) && (cnt_r == DATA_LAST)));
      avail_s     = buf_v_r || fresh_s;
      late_s      = load_s && !avail_s;
      if (buf_v_r) begin
         load_word_s = buf_r;
      end else if (fresh_s) begin
         load_word_s = mem_rdata;
      end else begin
         load_word_s = {DATA_W{1'b0}};
      end
      rd_start_s  = addr_done_s && op_r;
      // A late word defers the next prefetch until the stale response drains
      rd_issue_s  = ss_act_s && ((load_s && avail_s) || (rsp_s && stale_r));
      wr_issue_s  = ss_act_s && (state_r == WDATA) && wpend_r;
   end

   // Bit counter for address, data and turnaround phases
   always_ff @(posedge clk) begin
      if (rst || SS_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ADDR:    cnt_r <= addr_done_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            WDATA:   cnt_r <= word_done_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            RTURN:   cnt_r <= load_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            RDATA:   cnt_r <= load_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            default: cnt_r <= {CNT_W{1'b0}};
         endcase
      end
   end

   // Receive path: op bit, address shifter, data shifter and completed-word holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= 1'b0;
         addr_sh_r <= {(ADDR_W-1){1'b0}};
         rx_sh_r   <= {(DATA_W-1){1'b0}};
         hold_r    <= {DATA_W{1'b0}};
         wpend_r   <= 1'b0;
      end else if (SS_n) begin
         wpend_r   <= 1'b0;
      end else begin
         if (state_r == IDLE) begin
            op_r <= MOSI;
         end
         if (state_r == ADDR) begin
            addr_sh_r <= addr_full_s[ADDR_W-2:0];
         end
         if (state_r == WDATA) begin
            rx_sh_r <= word_full_s[DATA_W-2:0];
         end
         if (word_done_s) begin
            hold_r  <= word_full_s;
            wpend_r <= 1'b1;
         end else if (wr_issue_s) begin
            wpend_r <= 1'b0;
         end
      end
   end

   // Memory port, prefetch buffer, transmit shifter and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         rd_pend_r <= 1'b0;
         stale_r   <= 1'b0;
         buf_r     <= {DATA_W{1'b0}};
         buf_v_r   <= 1'b0;
         tx_sh_r   <= {DATA_W{1'b0}};
         MISO      <= 1'b0;
         rd_err    <= 1'b0;
      end else if (SS_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         rd_pend_r <= 1'b0;
         stale_r   <= 1'b0;
         buf_v_r   <= 1'b0;
         MISO      <= 1'b0;
      end else begin
         mem_req <= rd_start_s || rd_issue_s || wr_issue_s;
         mem_we  <= wr_issue_s;
         if (wr_issue_s) begin
            mem_addr  <= addr_r;
            mem_wdata <= hold_r;
            addr_r    <= addr_r + ADDR_W'(1);
         end else if (rd_start_s) begin
            mem_addr <= addr_full_s;
            addr_r   <= addr_full_s + ADDR_W'(1);
         end else if (rd_issue_s) begin
            mem_addr <= addr_r;
            addr_r   <= addr_r + ADDR_W'(1);
         end else if (addr_done_s) begin
            addr_r <= addr_full_s;
         end

         if (rd_start_s || rd_issue_s) begin
            rd_pend_r <= 1'b1;
         end else if (rsp_s) begin
            rd_pend_r <= 1'b0;
         end

         if (late_s && !rsp_s) begin
            stale_r <= 1'b1;
         end else if (rsp_s) begin
            stale_r <= 1'b0;
         end

         if (load_s) begin
            buf_v_r <= 1'b0;
         end else if (fresh_s) begin
            buf_r   <= mem_rdata;
            buf_v_r <= 1'b1;
         end

         if (late_s) begin
            rd_err <= 1'b1;
         end

         if (load_s) begin
            MISO    <= load_word_s[DATA_W-1];
            tx_sh_r <= load_word_s << 1;
         end else if (state_r == RDATA) begin
            MISO    <= tx_sh_r[DATA_W-1];
            tx_sh_r <= tx_sh_r << 1;
         end else begin
            MISO <= 1'b0;
         end
      end
   end

   // busy mirrors the registered state
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
      end else begin
         busy <= (state_s != IDLE);
      end
   end

endmodule
